// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl
//   Entry-gate controller for a parking lot. A car at the front sensor is asked
//   for a passcode. A correct code opens the gate. Repeated wrong codes lock the
//   gate out for a while. The module keeps a count of the parked cars.
//
// Handshake: pass_in is sampled only in a cycle where pass_valid is high. Each
//   high cycle of pass_valid is one code submission. There is no back-pressure,
//   so the controller accepts every strobe. Strobes are ignored while LOCKED.
//
// Ports
//   clock_in      single clock, rising edge
//   rst_in        synchronous active-high reset
//   Front_Sensor  car waiting at the entry gate
//   Back_Sensor   car has driven through the gate
//   Exit_Sensor   one-cycle pulse per car leaving the lot
//   pass_in       submitted passcode, qualified by pass_valid
//   pass_valid    one-cycle submission strobe
//   G_LED         gate open
//   R_LED         entry refused (wrong code, tailgate stop, lockout, lot full)
//   alarm         lockout active
//   full          count == CAPACITY
//   count         cars currently parked
//   state_code    current FSM state (debug / observability)
module parking_gate_ctrl #(
    parameter int                PASS_W      = 4,
    parameter logic [PASS_W-1:0] PASSCODE    = 4'b0110,
    parameter int                CAPACITY    = 8,
    parameter int                MAX_TRIES   = 3,
    parameter int                WAIT_CYCLES = 16,
    parameter int                LOCK_CYCLES = 32
) (
    input  logic                          clock_in,
    input  logic                          rst_in,
    input  logic                          Front_Sensor,
    input  logic                          Back_Sensor,
    input  logic                          Exit_Sensor,
    input  logic [PASS_W-1:0]             pass_in,
    input  logic                          pass_valid,
    output logic                          G_LED,
    output logic                          R_LED,
    output logic                          alarm,
    output logic                          full,
    output logic [$clog2(CAPACITY+1)-1:0] count,
    output logic [2:0]                    state_code
);

    localparam int CNT_W   = $clog2(CAPACITY + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PASS = 3'd1,
        S_WRONG     = 3'd2,
        S_GRANT     = 3'd3,
        S_STOP      = 3'd4,
        S_LOCKED    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [TRY_W-1:0]   tries_q, tries_d, tries_inc;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               g_led_q, g_led_d;
    logic               r_led_q, r_led_d;
    logic               alarm_q, alarm_d;
    logic               full_w;
    logic               refuse;
    logic               entry_inc;
    logic               exit_dec;
    logic               code_ok;

    assign full_w    = (count_q == CNT_W'(CAPACITY));
    assign tries_inc = tries_q + TRY_W'(1);
    assign code_ok   = (pass_in == PASSCODE);
    assign entry_inc = (state_q == S_GRANT) && Back_Sensor;
    assign exit_dec  = Exit_Sensor && (count_q != '0);

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        timer_d = timer_q;
        refuse  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Front_Sensor) begin
                    if (full_w) begin
                        refuse = 1'b1;
                    end else begin
                        state_d = S_WAIT_PASS;
                        timer_d = '0;
                    end
                end
            end
            S_WAIT_PASS, S_WRONG: begin
                if (pass_valid) begin
                    // A submission restarts the inactivity timer.
                    timer_d = '0;
                    if (code_ok) begin
                        state_d = S_GRANT;
                        tries_d = '0;
                    end else begin
                        tries_d = tries_inc;
                        state_d = (tries_inc == TRY_W'(MAX_TRIES)) ? S_LOCKED : S_WRONG;
                    end
                end else if (timer_q == TMR_W'(WAIT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    tries_d = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_GRANT: begin
                // A second car on the front sensor as the first one passes is a tailgater.
                if (Back_Sensor) begin
                    state_d = Front_Sensor ? S_STOP : S_IDLE;
                end
            end
            S_STOP: begin
                if (pass_valid) begin
                    timer_d = '0;
                    if (code_ok) begin
                        state_d = S_GRANT;
                        tries_d = '0;
                    end else begin
                        tries_d = tries_inc;
                        state_d = (tries_inc == TRY_W'(MAX_TRIES)) ? S_LOCKED : S_WRONG;
                    end
                end
            end
            S_LOCKED: begin
                if (timer_q == TMR_W'(LOCK_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    tries_d = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tries_d = '0;
                timer_d = '0;
            end
        endcase

        // An entry and an exit in the same cycle cancel out. An entry into a full lot saturates.
        count_d = count_q;
        if (entry_inc && !exit_dec) begin
            count_d = full_w ? count_q : count_q + CNT_W'(1);
        end else if (exit_dec && !entry_inc) begin
            count_d = count_q - CNT_W'(1);
        end

        // The outputs are decoded from the next state, so they change together with state_code.
        g_led_d = (state_d == S_GRANT);
        alarm_d = (state_d == S_LOCKED);
        r_led_d = refuse || (state_d == S_WRONG) || (state_d == S_STOP) ||
                  (state_d == S_LOCKED);
    end

    always_ff @(posedge clock_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            tries_q <= '0;
            timer_q <= '0;
            count_q <= '0;
            g_led_q <= 1'b0;
            r_led_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
            count_q <= count_d;
            g_led_q <= g_led_d;
            r_led_q <= r_led_d;
            alarm_q <= alarm_d;
        end
    end

    assign G_LED      = g_led_q;
    assign R_LED      = r_led_q;
    assign alarm      = alarm_q;
    assign full       = full_w;
    assign count      = count_q;
    assign state_code = state_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Testbench for parking_gate_ctrl. It applies a fixed vector table, then
// hand-written corner-case sequences, then random traffic. Every cycle it
// compares the outputs with a rule-level reference model.
module tb_parking_gate_ctrl;

    localparam int         CAP   = 8;
    localparam int         MAXT  = 3;
    localparam int         WAITC = 16;
    localparam int         LOCKC = 32;
    localparam logic [3:0] PC    = 4'b0110;

    logic       clk = 1'b0;
    logic       rst;
    logic       front_s, back_s, exit_s, pv;
    logic [3:0] code;
    logic       g_led, r_led, alarm_o, full_o;
    logic [3:0] count_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state. States use the published codes 0..5.
    int m_state, m_count, m_tries, m_timer;
    bit m_refused;

    always #5 clk = ~clk;

    parking_gate_ctrl #(
        .PASS_W(4), .PASSCODE(PC), .CAPACITY(CAP), .MAX_TRIES(MAXT),
        .WAIT_CYCLES(WAITC), .LOCK_CYCLES(LOCKC)
    ) dut (
        .clock_in    (clk),
        .rst_in      (rst),
        .Front_Sensor(front_s),
        .Back_Sensor (back_s),
        .Exit_Sensor (exit_s),
        .pass_in     (code),
        .pass_valid  (pv),
        .G_LED       (g_led),
        .R_LED       (r_led),
        .alarm       (alarm_o),
        .full        (full_o),
        .count       (count_o),
        .state_code  (state_o)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applies one clock of the lot rules to the model.
    task automatic model_step(input bit r, input bit fs, input bit bs, input bit es,
                              input bit v, input logic [3:0] c);
        int  ns;
        bit  entering, leaving;
        if (r) begin
            m_state = 0; m_count = 0; m_tries = 0; m_timer = 0; m_refused = 0;
            return;
        end
        ns        = m_state;
        m_refused = 0;
        entering  = (m_state == 3) && bs;
        leaving   = es && (m_count > 0);
        case (m_state)
            0: begin
                if (fs && m_count == CAP) m_refused = 1;
                else if (fs) begin ns = 1; m_timer = 0; end
            end
            1, 2, 4: begin
                if (v) begin
                    m_timer = 0;
                    if (c == PC) begin ns = 3; m_tries = 0; end
                    else begin
                        m_tries = m_tries + 1;
                        ns = (m_tries == MAXT) ? 5 : 2;
                    end
                end else if (m_state != 4) begin
                    m_timer = m_timer + 1;
                    if (m_timer == WAITC) begin ns = 0; m_tries = 0; m_timer = 0; end
                end
            end
            3: if (bs) ns = fs ? 4 : 0;
            5: begin
                m_timer = m_timer + 1;
                if (m_timer == LOCKC) begin ns = 0; m_tries = 0; m_timer = 0; end
            end
            default: ns = 0;
        endcase
        if (entering && !leaving) m_count = (m_count + 1 > CAP) ? CAP : m_count + 1;
        else if (leaving && !entering) m_count = m_count - 1;
        m_state = ns;
    endtask

    // Drives one cycle and compares every output with the model.
    task automatic apply(input bit r, input bit fs, input bit bs, input bit es,
                         input bit v, input logic [3:0] c);
        rst = r; front_s = fs; back_s = bs; exit_s = es; pv = v; code = c;
        @(posedge clk);
        model_step(r, fs, bs, es, v, c);
        #1;
        check("state_code", int'(state_o), m_state);
        check("G_LED", int'(g_led), int'(m_state == 3));
        check("R_LED", int'(r_led), int'(m_refused || m_state == 2 || m_state == 4 || m_state == 5));
        check("alarm", int'(alarm_o), int'(m_state == 5));
        check("count", int'(count_o), m_count);
        check("full", int'(full_o), int'(m_count == CAP));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 4'h0);
    endtask

    task automatic admit_car();
        apply(0, 1, 0, 0, 0, 4'h0);
        apply(0, 0, 0, 0, 1, PC);
        apply(0, 0, 1, 0, 0, 4'h0);
    endtask

    typedef struct {
        bit         fs, bs, es, v;
        logic [3:0] c;
        int         st;
        bit         g, r;
        int         cnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Entry, wrong code, tailgate, then simultaneous entry/exit and exits down to zero.
        vecs[0]  = '{fs:1, bs:0, es:0, v:0, c:4'h0, st:1, g:0, r:0, cnt:0};
        vecs[1]  = '{fs:0, bs:0, es:0, v:1, c:PC,   st:3, g:1, r:0, cnt:0};
        vecs[2]  = '{fs:0, bs:1, es:0, v:0, c:4'h0, st:0, g:0, r:0, cnt:1};
        vecs[3]  = '{fs:1, bs:0, es:0, v:0, c:4'h0, st:1, g:0, r:0, cnt:1};
        vecs[4]  = '{fs:0, bs:0, es:0, v:1, c:4'hF, st:2, g:0, r:1, cnt:1};
        vecs[5]  = '{fs:0, bs:0, es:0, v:1, c:PC,   st:3, g:1, r:0, cnt:1};
        vecs[6]  = '{fs:1, bs:1, es:0, v:0, c:4'h0, st:4, g:0, r:1, cnt:2};
        vecs[7]  = '{fs:0, bs:0, es:0, v:1, c:PC,   st:3, g:1, r:0, cnt:2};
        vecs[8]  = '{fs:0, bs:1, es:1, v:0, c:4'h0, st:0, g:0, r:0, cnt:2};
        vecs[9]  = '{fs:0, bs:0, es:1, v:0, c:4'h0, st:0, g:0, r:0, cnt:1};
        vecs[10] = '{fs:0, bs:0, es:1, v:0, c:4'h0, st:0, g:0, r:0, cnt:0};
        vecs[11] = '{fs:0, bs:0, es:1, v:0, c:4'h0, st:0, g:0, r:0, cnt:0};

        // Reset state.
        apply(1, 0, 0, 0, 0, 4'h0);
        apply(1, 1, 1, 1, 1, PC);
        check("rst_state", int'(state_o), 0);
        check("rst_outs", int'({g_led, r_led, alarm_o, full_o}), 0);
        check("rst_count", int'(count_o), 0);

        // Vector table.
        for (int i = 0; i < 12; i++) begin
            apply(0, vecs[i].fs, vecs[i].bs, vecs[i].es, vecs[i].v, vecs[i].c);
            check($sformatf("vec%0d_state", i), int'(state_o), vecs[i].st);
            check($sformatf("vec%0d_g", i), int'(g_led), int'(vecs[i].g));
            check($sformatf("vec%0d_r", i), int'(r_led), int'(vecs[i].r));
            check($sformatf("vec%0d_count", i), int'(count_o), vecs[i].cnt);
        end

        // Lockout: three wrong codes, a correct code is ignored, release after 32 clocks.
        apply(0, 1, 0, 0, 0, 4'h0);
        apply(0, 0, 0, 0, 1, 4'hF);
        check("lock_wrong1", int'(state_o), 2);
        apply(0, 0, 0, 0, 1, 4'hF);
        check("lock_wrong2", int'(state_o), 2);
        apply(0, 0, 0, 0, 1, 4'hF);
        check("lock_enter", int'(state_o), 5);
        check("lock_alarm", int'(alarm_o), 1);
        apply(0, 0, 0, 0, 1, PC);
        check("lock_ignore", int'(state_o), 5);
        idle(30);
        check("lock_still", int'(state_o), 5);
        idle(1);
        check("lock_release", int'(state_o), 0);
        check("lock_alarm_off", int'(alarm_o), 0);

        // Timeout: sixteen idle clocks in WAIT_PASS return to IDLE.
        apply(0, 1, 0, 0, 0, 4'h0);
        idle(15);
        check("tmo_before", int'(state_o), 1);
        idle(1);
        check("tmo_after", int'(state_o), 0);

        // Full lot: refusal, exit, then a tailgate that saturates the count.
        for (int i = 0; i < 8; i++) admit_car();
        check("full_count", int'(count_o), 8);
        check("full_flag", int'(full_o), 1);
        apply(0, 1, 0, 0, 0, 4'h0);
        check("full_refuse_st", int'(state_o), 0);
        check("full_refuse_r", int'(r_led), 1);
        apply(0, 0, 0, 1, 0, 4'h0);
        check("full_exit_count", int'(count_o), 7);
        check("full_exit_flag", int'(full_o), 0);
        apply(0, 1, 0, 0, 0, 4'h0);
        apply(0, 0, 0, 0, 1, PC);
        apply(0, 1, 1, 0, 0, 4'h0);
        check("tail_stop", int'(state_o), 4);
        check("tail_count", int'(count_o), 8);
        apply(0, 0, 0, 0, 1, PC);
        check("tail_regrant", int'(state_o), 3);
        apply(0, 0, 1, 0, 0, 4'h0);
        check("sat_count", int'(count_o), 8);
        check("sat_state", int'(state_o), 0);

        // Reset in the middle of LOCKED with five cars parked.
        apply(1, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 5; i++) admit_car();
        apply(0, 1, 0, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 1, 4'h9);
        idle(5);
        check("mid_lock_state", int'(state_o), 5);
        check("mid_lock_count", int'(count_o), 5);
        apply(1, 0, 0, 0, 0, 4'h0);
        check("rst_lock_state", int'(state_o), 0);
        check("rst_lock_count", int'(count_o), 0);
        check("rst_lock_alarm", int'(alarm_o), 0);

        // Random traffic: sparse exits first so the lot fills, then heavier exits.
        for (int i = 0; i < 4000; i++) begin
            bit         r, fs, bs, es, v;
            logic [3:0] c;
            r  = ($urandom_range(0, 299) == 0);
            fs = 1'($urandom_range(0, 1));
            bs = 1'($urandom_range(0, 1));
            es = (i < 2000) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
            v  = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 1) == 1) ? PC : 4'($urandom_range(0, 15));
            apply(r, fs, bs, es, v, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
